// File: rtl/timer_pkg.sv
// Shared types and constants for the seconds-timer command front-end.
package timer_pkg;

  localparam int SECONDS_W = 6;
  localparam int CMD_W     = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_MODE  = 2'b01,
    OP_QUERY = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    GAP   = 2'b10,
    RESP  = 2'b11
  } state_e;

  typedef struct packed {
    logic                 pause;
    logic                 forward;
    logic [SECONDS_W-1:0] seconds;
  } rsp_t;

endpackage

// File: rtl/timer_cmd_parity.sv
// Combinational odd-parity check over a command byte and its parity bit.
module timer_cmd_parity
  import timer_pkg::*;
(
  input  logic [CMD_W-1:0] cmd_byte,
  input  logic             cmd_par,
  output logic             par_ok
);

  assign par_ok = ^{cmd_par, cmd_byte};

endmodule

// File: rtl/timer_cmd_decoder.sv
// Command decoder driving the seconds timer (load/mode/query) with a response channel.
// Define TIMER_CMD_PARITY_EN to add the cmd_par input and odd-parity rejection.
module timer_cmd_decoder
  import timer_pkg::*;
#(
  parameter int WRITE_HOLD = 4,
  parameter int WRITE_GAP  = 4,
  parameter int MAX_VALUE  = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CMD_W-1:0]     cmd_byte,
`ifdef TIMER_CMD_PARITY_EN
  input  logic                 cmd_par,
`endif
  output logic [SECONDS_W-1:0] tmr_data,
  output logic                 tmr_write,
  output logic                 tmr_pause,
  output logic                 tmr_forward,
  input  logic [SECONDS_W-1:0] tmr_seconds,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CMD_W-1:0]     rsp_data,
  output logic                 err_sticky,
  input  logic                 err_clr
);

  localparam int CNT_MAX = (WRITE_HOLD > WRITE_GAP) ? WRITE_HOLD : WRITE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]     HOLD_LOAD = CNT_W'(WRITE_HOLD - 1);
  localparam logic [CNT_W-1:0]     GAP_LOAD  = CNT_W'(WRITE_GAP - 1);
  localparam logic [SECONDS_W-1:0] MAX_V     = SECONDS_W'(MAX_VALUE);

  state_e               state, next_state;
  logic [CNT_W-1:0]     cnt;
  rsp_t                 rsp_q;
  op_e                  op;
  logic [SECONDS_W-1:0] arg;
  logic                 par_ok;
  logic                 accept;
  logic                 load_ok, mode_ok, query_ok, reject;

  assign op       = op_e'(cmd_byte[7:6]);
  assign arg      = cmd_byte[SECONDS_W-1:0];
  assign accept   = cmd_valid && cmd_ready;
  assign rsp_data = rsp_q;

`ifdef TIMER_CMD_PARITY_EN
  timer_cmd_parity u_parity (
    .cmd_byte (cmd_byte),
    .cmd_par  (cmd_par),
    .par_ok   (par_ok)
  );
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Parity failures are consumed by the handshake but otherwise only raise the error flag.
  always_comb begin
    next_state = state;
    load_ok    = 1'b0;
    mode_ok    = 1'b0;
    query_ok   = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!par_ok) begin
            reject = 1'b1;
          end else begin
            case (op)
              OP_LOAD: begin
                if (arg > MAX_V) begin
                  reject = 1'b1;
                end else begin
                  load_ok    = 1'b1;
                  next_state = WRITE;
                end
              end
              OP_MODE:  mode_ok = 1'b1;
              OP_QUERY: begin
                query_ok   = 1'b1;
                next_state = RESP;
              end
              default:  reject = 1'b1;
            endcase
          end
        end
      end
      WRITE:   if (cnt == '0) next_state = GAP;
      GAP:     if (cnt == '0) next_state = IDLE;
      RESP:    if (rsp_valid && rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready   <= 1'b0;
      tmr_write   <= 1'b0;
      tmr_data    <= '0;
      tmr_pause   <= 1'b1;
      tmr_forward <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_q       <= '0;
      err_sticky  <= 1'b0;
      cnt         <= '0;
    end else begin
      cmd_ready <= (next_state == IDLE);
      tmr_write <= (next_state == WRITE);

      case (state)
        IDLE:    if (load_ok) cnt <= HOLD_LOAD;
        WRITE:   cnt <= (cnt == '0) ? GAP_LOAD : cnt - 1'b1;
        GAP:     if (cnt != '0) cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      if (load_ok) tmr_data <= arg;
      if (mode_ok) begin
        tmr_pause   <= arg[0];
        tmr_forward <= arg[1];
      end

      if (query_ok) begin
        rsp_q     <= '{pause: tmr_pause, forward: tmr_forward, seconds: tmr_seconds};
        rsp_valid <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      // A rejection in the same cycle as a clear keeps the flag set.
      if (reject)       err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_cmd_decoder.sv
// Directed self-checking bench for timer_cmd_decoder (handles TIMER_CMD_PARITY_EN builds too).
module tb_timer_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_byte;
  logic       cmd_par;
  logic [5:0] tmr_data;
  logic       tmr_write;
  logic       tmr_pause;
  logic       tmr_forward;
  logic [5:0] tmr_seconds;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       err_sticky;
  logic       err_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timer_cmd_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_byte    (cmd_byte),
`ifdef TIMER_CMD_PARITY_EN
    .cmd_par     (cmd_par),
`endif
    .tmr_data    (tmr_data),
    .tmr_write   (tmr_write),
    .tmr_pause   (tmr_pause),
    .tmr_forward (tmr_forward),
    .tmr_seconds (tmr_seconds),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one command for a single cycle; bad_par inverts the correct odd parity bit.
  task automatic applyStimulus(input logic [7:0] b, input logic bad_par);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    cmd_par   = bad_par ? ^b : ~^b;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_byte    = 8'h00;
    cmd_par     = 1'b1;
    tmr_seconds = 6'd7;
    rsp_ready   = 1'b1;
    err_clr     = 1'b0;
    tick();
    tick();

    checkOutput("rst_cmd_ready",   cmd_ready,   0);
    checkOutput("rst_tmr_data",    tmr_data,    0);
    checkOutput("rst_tmr_write",   tmr_write,   0);
    checkOutput("rst_tmr_pause",   tmr_pause,   1);
    checkOutput("rst_tmr_forward", tmr_forward, 1);
    checkOutput("rst_rsp_valid",   rsp_valid,   0);
    checkOutput("rst_rsp_data",    rsp_data,    0);
    checkOutput("rst_err_sticky",  err_sticky,  0);

    rst_n = 1'b1;
    tick();
    checkOutput("ready_after_reset", cmd_ready, 1);

    // LOAD 5: write high for cycles 1-4, low for 5-8, ready again at cycle 9.
    applyStimulus(8'h05, 1'b0);
    checkOutput("load5_data", tmr_data, 5);
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("load5_write_c%0d", i), tmr_write, (i <= 4) ? 1 : 0);
      checkOutput($sformatf("load5_ready_c%0d", i), cmd_ready, 0);
      tick();
    end
    checkOutput("load5_ready_c9", cmd_ready, 1);
    checkOutput("load5_err",      err_sticky, 0);

    // LOAD 12 exceeds the limit: rejected, no strobe, data unchanged.
    applyStimulus(8'h0C, 1'b0);
    checkOutput("load12_err",   err_sticky, 1);
    checkOutput("load12_write", tmr_write,  0);
    checkOutput("load12_ready", cmd_ready,  1);
    checkOutput("load12_data",  tmr_data,   5);
    tick();
    checkOutput("load12_write2", tmr_write, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("err_clr", err_sticky, 0);

    // LOAD at exactly the limit is accepted.
    applyStimulus(8'h09, 1'b0);
    checkOutput("load9_data",  tmr_data,   9);
    checkOutput("load9_write", tmr_write,  1);
    checkOutput("load9_err",   err_sticky, 0);
    repeat (8) tick();
    checkOutput("load9_ready", cmd_ready, 1);

    // Reserved opcode together with err_clr: the rejection wins.
    err_clr = 1'b1;
    applyStimulus(8'hC0, 1'b0);
    err_clr = 1'b0;
    checkOutput("rsvd_vs_clr_err", err_sticky, 1);
    checkOutput("rsvd_ready",      cmd_ready,  1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("rsvd_clr", err_sticky, 0);

    // MODE 0x41 then QUERY with seconds=7.
    applyStimulus(8'h41, 1'b0);
    checkOutput("mode41_pause",   tmr_pause,   1);
    checkOutput("mode41_forward", tmr_forward, 0);
    checkOutput("mode41_ready",   cmd_ready,   1);
    applyStimulus(8'h80, 1'b0);
    checkOutput("query_valid", rsp_valid, 1);
    checkOutput("query_data",  rsp_data,  8'h87);
    checkOutput("query_ready", cmd_ready, 0);
    tick();
    checkOutput("query_done_valid", rsp_valid, 0);
    checkOutput("query_done_ready", cmd_ready, 1);

    // Response back-pressure: hold for 10 cycles while commands are offered.
    applyStimulus(8'h42, 1'b0);
    checkOutput("mode42_pause",   tmr_pause,   0);
    checkOutput("mode42_forward", tmr_forward, 1);
    rsp_ready   = 1'b0;
    tmr_seconds = 6'h2A;
    applyStimulus(8'h80, 1'b0);
    tmr_seconds = 6'h03;
    cmd_valid   = 1'b1;
    cmd_byte    = 8'h01;
    cmd_par     = ~^cmd_byte;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("hold_valid_%0d", i), rsp_valid, 1);
      checkOutput($sformatf("hold_data_%0d", i),  rsp_data,  8'h6A);
      checkOutput($sformatf("hold_ready_%0d", i), cmd_ready, 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checkOutput("hold_release_valid", rsp_valid, 0);
    checkOutput("hold_release_ready", cmd_ready, 1);
    checkOutput("hold_load_ignored",  tmr_data,  9);
    tick();
    checkOutput("hold_no_write", tmr_write, 0);

    // Reset during WRITE cycle 2 drops everything at once.
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h03, 1'b0);
    tick();
    checkOutput("midrst_write_before", tmr_write, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_write",   tmr_write,   0);
    checkOutput("midrst_pause",   tmr_pause,   1);
    checkOutput("midrst_forward", tmr_forward, 1);
    checkOutput("midrst_data",    tmr_data,    0);
    checkOutput("midrst_ready",   cmd_ready,   0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("postrst_ready", cmd_ready, 1);
    checkOutput("postrst_write", tmr_write, 0);

`ifdef TIMER_CMD_PARITY_EN
    // 0x03 has even weight, so cmd_par must be 1 for an odd total.
    applyStimulus(8'h03, 1'b1);
    checkOutput("par_bad_err",   err_sticky, 1);
    checkOutput("par_bad_write", tmr_write,  0);
    checkOutput("par_bad_data",  tmr_data,   0);
    checkOutput("par_bad_ready", cmd_ready,  1);
    applyStimulus(8'h03, 1'b0);
    checkOutput("par_good_data",  tmr_data,  3);
    checkOutput("par_good_write", tmr_write, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
